// File: rtl/dispenser_pkg.sv
// Shared types and defaults for the water dispense controller.
// States are binary-encoded; the timing defaults are also the top-level parameter defaults.
package dispenser_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DISPENSING = 2'd1,
    COOLDOWN   = 2'd2
  } state_e;

  localparam int DEFAULT_DISPENSE_CYCLES = 8;
  localparam int DEFAULT_COOLDOWN_CYCLES = 4;

endpackage

// File: rtl/dispense_controller.sv
// Drives the water valve from button presses: timed dispense, cancel on re-press or empty tank, then cooldown.
// Latency: valve opens on the edge that samples an accepted press; all outputs are registered.
// Backpressure: none; presses during cooldown are dropped and presses on an empty tank pulse refused.
module dispense_controller
  import dispenser_pkg::*;
#(
  parameter int DISPENSE_CYCLES = DEFAULT_DISPENSE_CYCLES,
  parameter int COOLDOWN_CYCLES = DEFAULT_COOLDOWN_CYCLES,
  parameter int TIMER_WIDTH     = 16,
  parameter int COUNT_WIDTH     = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   button_was_pressed,
  input  logic                   tank_empty,
  output logic                   valve_open,
  output logic                   busy,
  output logic                   refused,
  output logic [COUNT_WIDTH-1:0] dispense_count
);

  // Timer counts down to zero, so a load of N-1 gives N cycles in the state.
  localparam logic [TIMER_WIDTH-1:0] DISPENSE_LOAD = TIMER_WIDTH'(DISPENSE_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] COOLDOWN_LOAD = TIMER_WIDTH'(COOLDOWN_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX     = '1;

  state_e                 state_q, state_d;
  logic [TIMER_WIDTH-1:0] timer_q, timer_d;
  logic                   refused_d;
  logic                   count_inc;
  logic [COUNT_WIDTH-1:0] count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      valve_open <= 1'b0;
      busy       <= 1'b0;
      refused    <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      valve_open <= (state_d == DISPENSING);
      busy       <= (state_d != IDLE);
      refused    <= refused_d;
      if (count_inc && (count_q != COUNT_MAX)) begin
        count_q <= count_q + COUNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    refused_d = 1'b0;
    count_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (button_was_pressed) begin
          if (tank_empty) begin
            refused_d = 1'b1;
          end else begin
            state_d = DISPENSING;
            timer_d = DISPENSE_LOAD;
          end
        end
      end
      DISPENSING: begin
        // An abort wins over natural completion even on the final cycle.
        if (tank_empty || button_was_pressed) begin
          state_d = COOLDOWN;
          timer_d = COOLDOWN_LOAD;
        end else if (timer_q == '0) begin
          state_d   = COOLDOWN;
          timer_d   = COOLDOWN_LOAD;
          count_inc = 1'b1;
        end else begin
          timer_d = timer_q - TIMER_WIDTH'(1);
        end
      end
      COOLDOWN: begin
        if (timer_q == '0) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q - TIMER_WIDTH'(1);
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  assign dispense_count = count_q;

endmodule

// File: tb/tb_dispense_controller.sv
// Scoreboard bench: an absolute-time model predicts per-edge outputs, a negedge monitor checks them.
// Two instances share stimulus; the second uses a 2-bit count to exercise saturation.
module tb_dispense_controller;

  localparam int DISP = 8;
  localparam int COOL = 4;

  logic       clock;
  logic       reset;
  logic       press;
  logic       tank_empty;
  logic       valve_open, busy, refused;
  logic [7:0] dispense_count;
  logic       valve_open_s, busy_s, refused_s;
  logic [1:0] dispense_count_s;

  dispense_controller #(
    .DISPENSE_CYCLES(DISP), .COOLDOWN_CYCLES(COOL), .TIMER_WIDTH(16), .COUNT_WIDTH(8)
  ) dut (
    .clock(clock), .reset(reset), .button_was_pressed(press), .tank_empty(tank_empty),
    .valve_open(valve_open), .busy(busy), .refused(refused), .dispense_count(dispense_count)
  );

  dispense_controller #(
    .DISPENSE_CYCLES(DISP), .COOLDOWN_CYCLES(COOL), .TIMER_WIDTH(16), .COUNT_WIDTH(2)
  ) dut_sat (
    .clock(clock), .reset(reset), .button_was_pressed(press), .tank_empty(tank_empty),
    .valve_open(valve_open_s), .busy(busy_s), .refused(refused_s), .dispense_count(dispense_count_s)
  );

  typedef struct {
    int   edge_no;
    logic valve;
    logic busy;
    logic refused;
    int   cnt;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Model state in absolute edge numbers: last edge after which the valve / busy is still high.
  int n           = 0;
  int valve_until = -1;
  int busy_until  = -1;
  int cnt         = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    valve_until = -1;
    busy_until  = -1;
    cnt         = 0;
  endtask

  task automatic model_edge(input logic p, input logic t);
    exp_t e;
    logic ref_now;
    ref_now = 1'b0;
    n++;
    if (n - 1 <= valve_until) begin
      if (t || p) begin
        valve_until = n - 1;
        busy_until  = n + COOL - 1;
      end else if (n - 1 == valve_until) begin
        cnt++;
      end
    end else if (n - 1 > busy_until) begin
      if (p && !t) begin
        valve_until = n + DISP - 1;
        busy_until  = n + DISP + COOL - 1;
      end else if (p && t) begin
        ref_now = 1'b1;
      end
    end
    e.edge_no = n;
    e.valve   = (n <= valve_until);
    e.busy    = (n <= busy_until);
    e.refused = ref_now;
    e.cnt     = cnt;
    exp_q.push_back(e);
  endtask

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check($sformatf("valve_open@%0d", e.edge_no), 32'(valve_open), 32'(e.valve));
      check($sformatf("busy@%0d", e.edge_no), 32'(busy), 32'(e.busy));
      check($sformatf("refused@%0d", e.edge_no), 32'(refused), 32'(e.refused));
      check($sformatf("count@%0d", e.edge_no), 32'(dispense_count), (e.cnt > 255) ? 255 : e.cnt);
      check($sformatf("valve_open_sat@%0d", e.edge_no), 32'(valve_open_s), 32'(e.valve));
      check($sformatf("busy_sat@%0d", e.edge_no), 32'(busy_s), 32'(e.busy));
      check($sformatf("refused_sat@%0d", e.edge_no), 32'(refused_s), 32'(e.refused));
      check($sformatf("count_sat@%0d", e.edge_no), 32'(dispense_count_s), (e.cnt > 3) ? 3 : e.cnt);
    end
  end

  task automatic step();
    @(posedge clock);
    if (!reset) model_edge(press, tank_empty);
    #1;
  endtask

  task automatic idle(input int k);
    press = 1'b0;
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic pulse();
    press = 1'b1;
    step();
    press = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valve"}, 32'(valve_open), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_refused"}, 32'(refused), 0);
    check({tag, "_count"}, 32'(dispense_count), 0);
    check({tag, "_valve_sat"}, 32'(valve_open_s), 0);
    check({tag, "_count_sat"}, 32'(dispense_count_s), 0);
  endtask

  initial begin
    int k;
    reset      = 1'b1;
    press      = 1'b0;
    tank_empty = 1'b0;
    #3;
    check_all_zero("reset_state");
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();

    // Full dispense followed by cooldown.
    pulse();
    idle(14);
    // Cancel by a second press three cycles in.
    pulse();
    idle(2);
    pulse();
    idle(8);
    // Refused on empty tank, then a press during cooldown is ignored.
    tank_empty = 1'b1;
    pulse();
    idle(2);
    tank_empty = 1'b0;
    pulse();
    idle(9);
    pulse();
    idle(5);
    // Tank runs empty mid-dispense; then press and empty together.
    pulse();
    idle(4);
    tank_empty = 1'b1;
    step();
    tank_empty = 1'b0;
    idle(6);
    pulse();
    idle(2);
    tank_empty = 1'b1;
    pulse();
    tank_empty = 1'b0;
    idle(6);

    // Asynchronous reset in the middle of a dispense.
    pulse();
    idle(3);
    @(negedge clock);
    #1;
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    pulse();
    idle(13);

    // Five full dispenses: the 2-bit count must stick at 3.
    for (int i = 0; i < 5; i++) begin
      pulse();
      idle(12);
    end

    // Randomized press / tank-level traffic.
    for (int i = 0; i < 1500; i++) begin
      press = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 39) == 0) tank_empty = ~tank_empty;
      step();
    end
    press      = 1'b0;
    tank_empty = 1'b0;

    k = 0;
    while (exp_q.size() > 0 && k < 10) begin
      @(negedge clock);
      k++;
    end
    #1;
    check("scoreboard_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
